// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the hart's instruction
// fetch port and data port. Data requests win over fetches. Only one read can
// be outstanding; the port frees in the same cycle its response returns, so
// back-to-back reads run at one per cycle with 1-cycle memory.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_imem_* / o_imem_*     fetch request (ren/raddr/ready), response (valid/rdata)
//   i_dmem_* / o_dmem_*     data request (ren/wen/addr/wdata/mask/ready), read response
//   o_mem_* / i_mem_*       shared memory request and response
//   o_stall_cnt             cycles a fetch request was held off (wraps)
//   o_bus_err               sticky: response timeout or stray response
module mem_arbiter #(
    parameter int TIMEOUT = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_imem_raddr,
    input  logic        i_imem_ren,
    output logic        o_imem_ready,
    output logic        o_imem_valid,
    output logic [31:0] o_imem_rdata,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_stall_cnt,
    output logic        o_bus_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] IWAIT = 2'd1;
    localparam logic [1:0] DWAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [31:0]   stall_q, stall_d;
    logic          err_q, err_d;

    logic busy_s, free_s, data_req_s, grant_d_s, grant_i_s, timeout_s, iready_s;

    assign busy_s     = (state_q != IDLE);
    assign free_s     = !busy_s || i_mem_valid;
    assign data_req_s = i_dmem_ren || i_dmem_wen;
    assign grant_d_s  = free_s && data_req_s;
    assign grant_i_s  = free_s && !data_req_s && i_imem_ren;
    // A wait cycle with the counter already at its last value is the forced completion.
    assign timeout_s  = busy_s && !i_mem_valid && (tmo_q == TMO_LAST);
    assign iready_s   = free_s && i_mem_ready && !data_req_s;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: hold while waiting, otherwise follow the accepted request.
    always_comb begin
        state_d = IDLE;
        if (busy_s && !i_mem_valid) begin
            state_d = timeout_s ? IDLE : state_q;
        end else if (grant_d_s && i_mem_ready) begin
            state_d = i_dmem_ren ? DWAIT : IDLE;
        end else if (grant_i_s && i_mem_ready) begin
            state_d = IWAIT;
        end else begin
            state_d = IDLE;
        end
    end

    // Output logic: combinational request and response steering.
    always_comb begin
        o_mem_addr   = 32'h0;
        o_mem_ren    = 1'b0;
        o_mem_wen    = 1'b0;
        o_mem_wdata  = 32'h0;
        o_mem_mask   = 4'h0;
        o_imem_valid = 1'b0;
        o_imem_rdata = 32'h0;
        o_dmem_valid = 1'b0;
        o_dmem_rdata = 32'h0;
        if (grant_d_s) begin
            o_mem_addr  = i_dmem_addr;
            o_mem_ren   = i_dmem_ren;
            o_mem_wen   = i_dmem_wen;
            o_mem_wdata = i_dmem_wdata;
            o_mem_mask  = i_dmem_mask;
        end else if (grant_i_s) begin
            o_mem_addr  = i_imem_raddr;
            o_mem_ren   = 1'b1;
            o_mem_mask  = 4'hF;
        end else begin
            o_mem_addr  = 32'h0;
        end
        case (state_q)
            IWAIT: begin
                o_imem_valid = i_mem_valid || timeout_s;
                o_imem_rdata = i_mem_valid ? i_mem_rdata : 32'h0;
            end
            DWAIT: begin
                o_dmem_valid = i_mem_valid || timeout_s;
                o_dmem_rdata = i_mem_valid ? i_mem_rdata : 32'h0;
            end
            default: begin
                o_imem_valid = 1'b0;
                o_dmem_valid = 1'b0;
            end
        endcase
    end

    assign o_imem_ready = iready_s;
    assign o_dmem_ready = free_s && i_mem_ready;

    // Next values of the timeout counter, stall counter and error flag.
    always_comb begin
        tmo_d   = (busy_s && !i_mem_valid && !timeout_s) ? (tmo_q + CW'(1)) : {CW{1'b0}};
        stall_d = (i_imem_ren && !iready_s) ? (stall_q + 32'd1) : stall_q;
        err_d   = err_q || timeout_s || (!busy_s && i_mem_valid);
    end

    // Counter and sticky error registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q   <= {CW{1'b0}};
            stall_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign o_stall_cnt = stall_q;
    assign o_bus_err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_raddr, dmem_addr, dmem_wdata, mem_rdata;
    logic        imem_ren, dmem_ren, dmem_wen, mem_ready, mem_valid;
    logic [3:0]  dmem_mask;
    logic        imem_ready, imem_valid, dmem_ready, dmem_valid;
    logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata, stall_cnt;
    logic        mem_ren, mem_wen, bus_err;
    logic [3:0]  mem_mask;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_imem_raddr(imem_raddr), .i_imem_ren(imem_ren),
        .o_imem_ready(imem_ready), .o_imem_valid(imem_valid), .o_imem_rdata(imem_rdata),
        .i_dmem_addr(dmem_addr), .i_dmem_ren(dmem_ren), .i_dmem_wen(dmem_wen),
        .i_dmem_wdata(dmem_wdata), .i_dmem_mask(dmem_mask),
        .o_dmem_ready(dmem_ready), .o_dmem_valid(dmem_valid), .o_dmem_rdata(dmem_rdata),
        .o_mem_addr(mem_addr), .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
        .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
        .i_mem_ready(mem_ready), .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata),
        .o_stall_cnt(stall_cnt), .o_bus_err(bus_err)
    );

    typedef struct {
        logic        iready, dready;
        logic [31:0] maddr;
        logic        mren, mwen;
        logic [31:0] mwdata;
        logic [3:0]  mmask;
        logic        ivalid, dvalid;
        logic [31:0] stall;
        logic        err;
    } rec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } rsp_t;

    rec_t rec_q[$];
    rsp_t rsp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: one outstanding read plus the memory's own latency plan.
    bit          m_out, m_isd, m_drop, m_rst;
    int          m_rem, m_waits;
    logic [31:0] m_addr, m_stall;
    bit          m_err;

    // Memory contents as a pure function of address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive hart and memory, record expectations, advance the model.
    task automatic cyc(input bit ireq, input logic [31:0] iaddr,
                       input bit dren, input bit dwen, input logic [31:0] daddr,
                       input logic [31:0] wdata, input logic [3:0] mask,
                       input bit mready, input int lat, input bit drop, input bit stray);
        rec_t r;
        rsp_t s;
        bit mv, free, dreq, gd, gi, tmo;
        if (m_out) m_rem--;
        mv   = (m_out && !m_drop && m_rem == 0) || (stray && !m_out);
        imem_ren   = ireq;  imem_raddr = iaddr;
        dmem_ren   = dren;  dmem_wen   = dwen;  dmem_addr = daddr;
        dmem_wdata = wdata; dmem_mask  = mask;
        mem_ready  = mready; mem_valid = mv;
        mem_rdata  = m_out ? memfn(m_addr) : 32'($urandom);
        free = !m_out || mv;
        tmo  = m_out && !mv && (m_waits == TMO - 1);
        dreq = dren || dwen;
        gd   = free && dreq;
        gi   = free && !dreq && ireq;
        r.dready = free && mready;
        r.iready = free && mready && !dreq;
        r.maddr  = gd ? daddr : (gi ? iaddr : 32'h0);
        r.mren   = gd ? dren : gi;
        r.mwen   = gd && dwen;
        r.mwdata = gd ? wdata : 32'h0;
        r.mmask  = gd ? mask : (gi ? 4'hF : 4'h0);
        r.ivalid = m_out && !m_isd && (mv || tmo);
        r.dvalid = m_out && m_isd && (mv || tmo);
        r.stall  = m_stall;
        r.err    = m_err;
        rec_q.push_back(r);
        if (!m_rst) begin
            if (ireq && !r.iready) m_stall++;
            if (tmo || (mv && !m_out)) m_err = 1'b1;
        end
        if (m_out && !mv && !tmo) begin
            m_waits++;
        end else begin
            m_out = 1'b0;
            if (((gd && dren) || gi) && mready) begin
                m_out   = 1'b1;
                m_isd   = gd;
                m_addr  = gd ? daddr : iaddr;
                m_rem   = lat;
                m_drop  = drop;
                m_waits = 0;
                s.is_d  = gd;
                s.data  = drop ? 32'h0 : memfn(m_addr);
                rsp_q.push_back(s);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rst_n   = 1'b0;
        m_out   = 1'b0;
        m_stall = 32'h0;
        m_err   = 1'b0;
        m_rst   = 1'b1;
        rsp_q.delete();
        for (int i = 0; i < n; i++) cyc(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 0);
        rst_n = 1'b1;
        m_rst = 1'b0;
    endtask

    // Monitor: compare every cycle's outputs and pop responses as they appear.
    always @(negedge clk) begin
        rec_t r;
        rsp_t s;
        if (rec_q.size() > 0) begin
            r = rec_q.pop_front();
            chk("imem_ready", 32'(imem_ready), 32'(r.iready));
            chk("dmem_ready", 32'(dmem_ready), 32'(r.dready));
            chk("mem_addr",   mem_addr,        r.maddr);
            chk("mem_ren",    32'(mem_ren),    32'(r.mren));
            chk("mem_wen",    32'(mem_wen),    32'(r.mwen));
            chk("mem_wdata",  mem_wdata,       r.mwdata);
            chk("mem_mask",   32'(mem_mask),   32'(r.mmask));
            chk("imem_valid", 32'(imem_valid), 32'(r.ivalid));
            chk("dmem_valid", 32'(dmem_valid), 32'(r.dvalid));
            chk("stall_cnt",  stall_cnt,       r.stall);
            chk("bus_err",    32'(bus_err),    32'(r.err));
            if (imem_valid || dmem_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(imem_valid || dmem_valid), 32'h0);
                end else begin
                    s = rsp_q.pop_front();
                    chk("rsp_src",  32'(dmem_valid), 32'(s.is_d));
                    chk("rsp_data", dmem_valid ? dmem_rdata : imem_rdata, s.data);
                end
            end else begin
                chk("imem_rdata_idle", imem_rdata, 32'h0);
                chk("dmem_rdata_idle", dmem_rdata, 32'h0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        imem_ren = 0; imem_raddr = 0; dmem_ren = 0; dmem_wen = 0; dmem_addr = 0;
        dmem_wdata = 0; dmem_mask = 0; mem_ready = 0; mem_valid = 0; mem_rdata = 0;
        m_out = 0; m_isd = 0; m_drop = 0; m_rst = 1; m_rem = 0; m_waits = 0;
        m_addr = 0; m_stall = 0; m_err = 0;
        @(posedge clk);
        #1;
        do_reset(3);
        idle(2);

        // Back-to-back fetches with 1-cycle memory.
        for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 0, 0);
        idle(2);

        // Fetch and data read collide; data wins, fetch follows.
        cyc(1, 32'h10, 1, 0, 32'h200, 32'h0, 4'hF, 1, 1, 0, 0);
        cyc(1, 32'h10, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 0, 0);
        idle(2);

        // Masked write, then a fetch.
        cyc(0, 32'h0, 0, 1, 32'h40, 32'hA5A5_1234, 4'b0011, 1, 1, 0, 0);
        cyc(1, 32'h20, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 0, 0);
        idle(2);

        // Backpressure: memory not ready for 3 cycles.
        for (int i = 0; i < 3; i++) cyc(1, 32'h30, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 0);
        cyc(1, 32'h30, 0, 0, 32'h0, 32'h0, 4'h0, 1, 2, 0, 0);
        idle(3);

        // Data read whose response never comes.
        cyc(0, 32'h0, 1, 0, 32'h300, 32'h0, 4'hF, 1, 1, 1, 0);
        idle(6);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            int sel;
            bit dr, dw;
            sel = int'($urandom_range(0, 7));
            dr  = (sel == 0);
            dw  = (sel == 1);
            cyc(($urandom_range(0, 3) != 0), {$urandom} & 32'hFFFF_FFFC,
                dr, dw, 32'($urandom), 32'($urandom), 4'($urandom),
                ($urandom_range(0, 3) != 0), int'($urandom_range(1, TMO)),
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 49) == 0));
        end
        idle(6);

        // Reset with a data read outstanding, then a late response.
        cyc(0, 32'h0, 1, 0, 32'h400, 32'h0, 4'hF, 1, 1, 1, 0);
        idle(1);
        do_reset(2);
        cyc(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 0, 1);
        idle(3);

        @(negedge clk);
        #1;
        chk("rsp_left", 32'(rsp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
